// File: rtl/regfile_pkg.sv
// regfile_pkg: shared widths, types and helpers for the register file with pending-write scoreboard
package regfile_pkg;
    localparam int DATA_W   = 32;
    localparam int NUM_REGS = 15;
    localparam int ADDR_W   = 4;
    localparam int PEND_W   = 2;

    localparam logic [PEND_W-1:0] PEND_MAX = '1;

    typedef logic [ADDR_W-1:0] reg_idx_t;
    typedef logic [DATA_W-1:0] reg_val_t;

    // Indices at or above the register count address nothing (R15/PC lives outside the file)
    function automatic logic in_range(input int unsigned idx, input int unsigned n = NUM_REGS);
        return idx < n;
    endfunction
endpackage

// File: rtl/regfile_pend_ctr.sv
// regfile_pend_ctr: saturating per-register count of issued-but-not-retired writes
module regfile_pend_ctr #(
    parameter int PEND_W = regfile_pkg::PEND_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inc,
    input  logic              dec,
    input  logic              clr,
    output logic [PEND_W-1:0] count,
    output logic              nonzero,
    output logic              full
);
    // Clear wins; issue and retire together cancel; retire at zero is ignored
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            count <= '0;
        else if (clr)
            count <= '0;
        else if (inc && !dec && !full)
            count <= count + PEND_W'(1);
        else if (dec && !inc && nonzero)
            count <= count - PEND_W'(1);
    end

    assign nonzero = |count;
    assign full    = &count;
endmodule

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: ID-stage register file, 2 read / 1 write ports, per-register pending-write scoreboard
// Optional same-cycle write-to-read bypass: define REGFILE_BYPASS_EN
module regfile_scoreboard #(
    parameter int DATA_W   = regfile_pkg::DATA_W,
    parameter int NUM_REGS = regfile_pkg::NUM_REGS,
    parameter int ADDR_W   = regfile_pkg::ADDR_W,
    parameter int PEND_W   = regfile_pkg::PEND_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [ADDR_W-1:0]   rd_addr_a,
    input  logic [ADDR_W-1:0]   rd_addr_b,
    output logic [DATA_W-1:0]   rd_data_a,
    output logic [DATA_W-1:0]   rd_data_b,
    output logic                hazard_a,
    output logic                hazard_b,
    input  logic                wr_en,
    input  logic [ADDR_W-1:0]   wr_addr,
    input  logic [DATA_W-1:0]   wr_data,
    input  logic                issue_en,
    input  logic [ADDR_W-1:0]   issue_addr,
    output logic                issue_rdy,
    input  logic                flush,
    output logic [NUM_REGS-1:0] busy_vec
);
    import regfile_pkg::*;

    logic [DATA_W-1:0]   regs [NUM_REGS];
    logic [PEND_W-1:0]   cnt  [NUM_REGS];
    logic [NUM_REGS-1:0] nz, full;
    logic                a_ok, b_ok, w_ok, i_ok, issue_ok, byp_a, byp_b;
    logic [ADDR_W-1:0]   a_idx, b_idx, i_idx;

    assign a_ok = in_range(32'(rd_addr_a), NUM_REGS);
    assign b_ok = in_range(32'(rd_addr_b), NUM_REGS);
    assign w_ok = wr_en && in_range(32'(wr_addr), NUM_REGS);
    assign i_ok = in_range(32'(issue_addr), NUM_REGS);

    // Clamp out-of-range indices so array selects never leave the array
    assign a_idx = a_ok ? rd_addr_a  : '0;
    assign b_idx = b_ok ? rd_addr_b  : '0;
    assign i_idx = i_ok ? issue_addr : '0;

    // Data array: reset loads each register with its own index
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_REGS; i++)
                regs[i] <= DATA_W'(i);
        end else if (w_ok) begin
            regs[wr_addr] <= wr_data;
        end
    end

    assign issue_rdy = !(i_ok && full[i_idx]);
    assign issue_ok  = issue_en && issue_rdy;

    for (genvar r = 0; r < NUM_REGS; r++) begin : g_pend
        regfile_pend_ctr #(.PEND_W(PEND_W)) u_ctr (
            .clk     (clk),
            .rst     (rst),
            .inc     (issue_ok && i_ok && issue_addr == ADDR_W'(r)),
            .dec     (w_ok && wr_addr == ADDR_W'(r)),
            .clr     (flush),
            .count   (cnt[r]),
            .nonzero (nz[r]),
            .full    (full[r])
        );
    end

    assign busy_vec = nz;

`ifdef REGFILE_BYPASS_EN
    assign byp_a = w_ok && wr_addr == rd_addr_a;
    assign byp_b = w_ok && wr_addr == rd_addr_b;
`else
    assign byp_a = 1'b0;
    assign byp_b = 1'b0;
`endif

    // Read muxes; a bypassed write that retires the last pending count lifts the hazard
    always_comb begin
        rd_data_a = byp_a ? wr_data : (a_ok ? regs[a_idx] : '0);
        rd_data_b = byp_b ? wr_data : (b_ok ? regs[b_idx] : '0);
        hazard_a  = a_ok && nz[a_idx] && !(byp_a && cnt[a_idx] == PEND_W'(1));
        hazard_b  = b_ok && nz[b_idx] && !(byp_b && cnt[b_idx] == PEND_W'(1));
    end
endmodule

// File: tb/tb_regfile_scoreboard.sv
// tb_regfile_scoreboard: directed stimulus with a queued-expectation scoreboard checked on the falling edge
module tb_regfile_scoreboard;
    import regfile_pkg::*;

    typedef enum int {K_RDA, K_RDB, K_HZA, K_HZB, K_RDY, K_BUSY} kind_t;
    typedef struct {
        string       name;
        kind_t       kind;
        logic [31:0] exp;
    } exp_t;

    logic                clk = 1'b0;
    logic                rst = 1'b0;
    reg_idx_t            rd_addr_a = '0, rd_addr_b = '0, wr_addr = '0, issue_addr = '0;
    reg_val_t            rd_data_a, rd_data_b, wr_data = '0;
    logic                hazard_a, hazard_b, issue_rdy;
    logic                wr_en = 1'b0, issue_en = 1'b0, flush = 1'b0;
    logic [NUM_REGS-1:0] busy_vec;

    exp_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    regfile_scoreboard dut (
        .clk        (clk),
        .rst        (rst),
        .rd_addr_a  (rd_addr_a),
        .rd_addr_b  (rd_addr_b),
        .rd_data_a  (rd_data_a),
        .rd_data_b  (rd_data_b),
        .hazard_a   (hazard_a),
        .hazard_b   (hazard_b),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .issue_en   (issue_en),
        .issue_addr (issue_addr),
        .issue_rdy  (issue_rdy),
        .flush      (flush),
        .busy_vec   (busy_vec)
    );

    always #5 clk = ~clk;

    // Monitor: every falling edge drains the expectations queued during this cycle
    always @(negedge clk) begin
        while (q.size() != 0) begin
            exp_t e;
            logic [31:0] act;
            e = q.pop_front();
            case (e.kind)
                K_RDA:   act = rd_data_a;
                K_RDB:   act = rd_data_b;
                K_HZA:   act = 32'(hazard_a);
                K_HZB:   act = 32'(hazard_b);
                K_RDY:   act = 32'(issue_rdy);
                default: act = 32'(busy_vec);
            endcase
            n_tests++;
            if (act !== e.exp) begin
                n_fail++;
                $display("FAIL %s: got %0h expected %0h", e.name, act, e.exp);
            end
        end
    end

    task automatic expect_val(input string name, input kind_t kind, input logic [31:0] exp);
        q.push_back('{name, kind, exp});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        wr_en    = 1'b0;
        issue_en = 1'b0;
        flush    = 1'b0;
    endtask

    task automatic issue(input int r);
        issue_en   = 1'b1;
        issue_addr = reg_idx_t'(r);
        step();
    endtask

    task automatic retire(input int r, input logic [31:0] d);
        wr_en   = 1'b1;
        wr_addr = reg_idx_t'(r);
        wr_data = d;
        step();
    endtask

    initial begin
        // Reset state, checked while reset is still held
        #2;
        expect_val("rst_busy", K_BUSY, 0);
        expect_val("rst_rdy", K_RDY, 1);
        expect_val("rst_hza", K_HZA, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;

        for (int i = 0; i < NUM_REGS; i++) begin
            rd_addr_a = reg_idx_t'(i);
            rd_addr_b = reg_idx_t'(NUM_REGS - 1 - i);
            expect_val($sformatf("rst_rd_a_R%0d", i), K_RDA, 32'(i));
            expect_val($sformatf("rst_rd_b_R%0d", NUM_REGS - 1 - i), K_RDB, 32'(NUM_REGS - 1 - i));
            step();
        end
        rd_addr_a = 4'd15;
        expect_val("oor_rd_a", K_RDA, 0);
        expect_val("oor_hz_a", K_HZA, 0);
        step();

        // Write then read
        rd_addr_a = 4'd3;
        wr_en = 1'b1; wr_addr = 4'd3; wr_data = 32'hDEADBEEF;
`ifdef REGFILE_BYPASS_EN
        expect_val("wr_same_cycle", K_RDA, 32'hDEADBEEF);
`else
        expect_val("wr_same_cycle", K_RDA, 32'd3);
`endif
        step();
        expect_val("wr_next_cycle", K_RDA, 32'hDEADBEEF);
        retire(15, 32'h1234);
        rd_addr_a = 4'd15;
        rd_addr_b = 4'd14;
        expect_val("oor_wr_rd15", K_RDA, 0);
        expect_val("oor_wr_R14", K_RDB, 32'd14);
        step();

        // Saturating issue to R5, then three retires
        rd_addr_a  = 4'd5;
        issue_addr = 4'd5;
        expect_val("r5_rdy0", K_RDY, 1);
        issue(5);
        issue(5);
        expect_val("r5_rdy2", K_RDY, 1);
        issue(5);
        expect_val("r5_rdy3", K_RDY, 0);
        expect_val("r5_busy3", K_BUSY, 32'h20);
        issue(5);
        expect_val("r5_drop_hz", K_HZA, 1);
        expect_val("r5_drop_rdy", K_RDY, 0);
        retire(5, 32'h0000_0501);
        expect_val("r5_ret1_rdy", K_RDY, 1);
        retire(5, 32'h0000_0502);
        expect_val("r5_ret2_hz", K_HZA, 1);
        retire(5, 32'h0000_0503);
        expect_val("r5_ret3_hz", K_HZA, 0);
        expect_val("r5_ret3_busy", K_BUSY, 0);
        expect_val("r5_data", K_RDA, 32'h0000_0503);
        step();

        // Simultaneous issue and retire on R2
        rd_addr_b = 4'd2;
        issue(2);
        expect_val("r2_hz_pre", K_HZB, 1);
        issue_en = 1'b1; issue_addr = 4'd2;
        wr_en = 1'b1; wr_addr = 4'd2; wr_data = 32'h22;
        step();
        expect_val("r2_hz_same", K_HZB, 1);
        expect_val("r2_busy_same", K_BUSY, 32'h4);
        expect_val("r2_data", K_RDB, 32'h22);
        // Issue R6 and retire R2 together: both update independently
        issue_en = 1'b1; issue_addr = 4'd6;
        wr_en = 1'b1; wr_addr = 4'd2; wr_data = 32'h23;
        step();
        expect_val("indep_busy", K_BUSY, 32'h40);
        expect_val("indep_hz_b", K_HZB, 0);
        retire(6, 32'h66);
        expect_val("r6_clear", K_BUSY, 0);
        step();

        // Flush discards pending counts; concurrent issue ignored, write kept
        issue(1);
        issue(1);
        issue(7);
        expect_val("pre_flush_busy", K_BUSY, 32'h82);
        flush = 1'b1;
        issue_en = 1'b1; issue_addr = 4'd4;
        wr_en = 1'b1; wr_addr = 4'd8; wr_data = 32'h88;
        step();
        rd_addr_a = 4'd8;
        rd_addr_b = 4'd1;
        expect_val("flush_busy", K_BUSY, 0);
        expect_val("flush_wr", K_RDA, 32'h88);
        expect_val("flush_hz_r1", K_HZB, 0);
        expect_val("flush_rdy_r4", K_RDY, 1);
        step();

        // Reset asserted mid-cycle with a write in flight
        retire(9, 32'h55);
        issue(9);
        issue(9);
        rd_addr_a = 4'd9;
        expect_val("r9_pre_data", K_RDA, 32'h55);
        expect_val("r9_pre_busy", K_BUSY, 32'h200);
        step();
        wr_en = 1'b1; wr_addr = 4'd9; wr_data = 32'h77;
        rst = 1'b0;
        #1;
        expect_val("mid_rst_data", K_RDA, 32'd9);
        expect_val("mid_rst_busy", K_BUSY, 0);
        expect_val("mid_rst_hz", K_HZA, 0);
        step();
        rst = 1'b1;
        step();
        expect_val("post_rst_data", K_RDA, 32'd9);
        step();

        repeat (2) @(posedge clk);
        if (q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
